running_remultiplier: RTL

//  Inverse of the running divider: rebuilds a = q*n + r from streamed blocks.

---
 rtl/running_remultiplier.sv | 128 ++++++++++++
 1 files changed

// File: rtl/running_remultiplier.sv
// Rebuilds a = q*n + r from LSB-first block streams using column-wise
// (product-scanning) multiply-accumulate, emitting 2*NUM_BLOCKS result blocks.
module running_remultiplier #(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     valid_in,
  input  logic [REGISTER_SIZE-1:0] q_block_in,
  input  logic [REGISTER_SIZE-1:0] n_block_in,
  input  logic [REGISTER_SIZE-1:0] r_block_in,
  output logic                     ready_out,
  output logic                     valid_out,
  output logic [REGISTER_SIZE-1:0] a_block_out,
  output logic                     last_out
);
  localparam int R  = REGISTER_SIZE;
  localparam int N  = NUM_BLOCKS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(2 * N);
  localparam int PW = 2 * R;
  localparam int AW = 2 * R + $clog2(N) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(2 * N - 1);
  localparam logic [KW-1:0] K_N    = KW'(N);
  localparam logic [IW-1:0] I_LAST = IW'(N - 1);

  // Handshake: a block beat transfers on a posedge where valid_in && ready_out;
  // ready_out is high only in IDLE/LOAD. valid_out is a one-cycle pulse per
  // result block with no backpressure; last_out accompanies the final block.
  typedef enum logic [1:0] {IDLE, LOAD, MAC, EMIT} state_t;

  state_t        state;
  logic [IW-1:0] load_idx;
  logic [IW-1:0] term_idx;
  logic [KW-1:0] col;
  logic [KW-1:0] col_next;
  logic [AW-1:0] acc;
  logic [R-1:0]  q_mem [N];
  logic [R-1:0]  n_mem [N];
  logic [R-1:0]  r_mem [N];
  logic          beat;
  logic [IW-1:0] n_idx;
  logic [PW-1:0] prod;
  logic [R-1:0]  r_add;
  logic [AW-1:0] emit_sum;

  // Highest and lowest q index contributing to column c.
  function automatic logic [IW-1:0] col_hi(input logic [KW-1:0] c);
    return (c < K_N) ? IW'(c) : I_LAST;
  endfunction

  function automatic logic [IW-1:0] col_lo(input logic [KW-1:0] c);
    return (c < K_N) ? '0 : IW'(c - KW'(N - 1));
  endfunction

  assign ready_out = (state == IDLE) || (state == LOAD);
  assign beat      = valid_in && ready_out;

  always_comb begin
    col_next = col + KW'(1);
    n_idx    = IW'(col - KW'(term_idx));
    prod     = PW'(q_mem[term_idx]) * PW'(n_mem[n_idx]);
    r_add    = (col < K_N) ? r_mem[IW'(col)] : '0;
    emit_sum = acc + AW'(r_add);
  end

  always_ff @(posedge clk_in) begin
    if (beat) begin
      q_mem[load_idx] <= q_block_in;
      n_mem[load_idx] <= n_block_in;
      r_mem[load_idx] <= r_block_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      load_idx    <= '0;
      term_idx    <= '0;
      col         <= '0;
      acc         <= '0;
      valid_out   <= 1'b0;
      a_block_out <= '0;
      last_out    <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      case (state)
        IDLE, LOAD: begin
          if (beat) begin
            if (load_idx == I_LAST) begin
              load_idx <= '0;
              col      <= '0;
              term_idx <= '0;
              acc      <= '0;
              state    <= MAC;
            end else begin
              load_idx <= load_idx + IW'(1);
              state    <= LOAD;
            end
          end
        end
        MAC: begin
          acc <= acc + AW'(prod);
          if (term_idx == col_hi(col)) state <= EMIT;
          else                         term_idx <= term_idx + IW'(1);
        end
        EMIT: begin
          a_block_out <= emit_sum[R-1:0];
          valid_out   <= 1'b1;
          acc         <= emit_sum >> R;
          if (col == K_LAST) begin
            last_out <= 1'b1;
            col      <= '0;
            state    <= IDLE;
          end else begin
            // The top column has no products, so it skips MAC entirely.
            col      <= col_next;
            term_idx <= col_lo(col_next);
            state    <= (col_next == K_LAST) ? EMIT : MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
